param_decoder: RTL and testbench
================================

# param_decoder

Parametrised, registered SEL_W-to-2^SEL_W one-hot decoder with a valid/ready input handshake and an optional timed sweep mode. It replaces the purely combinational 3-8 decoder in LED/board-demo designs. It drives one-hot outputs such as LED banks or chip selects directly, either holding a decoded code or stepping a single lit bit through every position at a programmable dwell rate.

## Interface
Parameters:
- SEL_W, default 3: select width; output width OUT_W = 2^SEL_W (derived, not overridable).
- CNT_MAX, default 24_999_999: sweep dwell counter terminal value; each sweep position is held for CNT_MAX+1 cycles (0.5 s at 50 MHz). Legal range is ≥ 0. The counter width is $clog2(CNT_MAX+1), minimum 1.

Ports:
- sys_clk  in  1  system clock; all logic on the rising edge.
- sys_rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request present.
- in_ready  out  1  block can accept; transfer occurs when in_valid && in_ready at a rising edge.
- in_sel  in  SEL_W  code to decode (direct) or sweep start position (sweep).
- mode  in  1  0 = direct, 1 = sweep; sampled only on transfer.
- out_val  out  OUT_W  one-hot output; bit k is out_val[k], LSB = bit 0.
- out_valid  out  1  high whenever out_val is non-zero.

## Operation
- States: IDLE, HOLD, SWEEP. The state, out_val, out_valid, dwell counter and step counter are all registered.
- Reset values: state IDLE, out_val 0, out_valid 0, in_ready 1, all counters 0. Reset asserted mid-operation clears all of these immediately, without waiting for a clock edge.
- in_ready = (state != SWEEP), decoded from the registered state.
- IDLE/HOLD, transfer with mode=0:
  - Next edge: out_val = 1 << in_sel, out_valid = 1, state HOLD.
  - Re-accepting the same code leaves the output unchanged.
- IDLE/HOLD, transfer with mode=1:
  - Next edge: out_val = 1 << in_sel, out_valid = 1, dwell counter 0, step counter 0, state SWEEP.
- HOLD with no transfer: out_val is held indefinitely.
- SWEEP:
  - The dwell counter increments every cycle.
  - When the dwell counter reaches CNT_MAX, it returns to 0 and the step counter increments.
  - If the step counter was < OUT_W-1, out_val rotates left by one, wrapping bit OUT_W-1 to bit 0.
  - If the step counter was OUT_W-1, out_val becomes 0, out_valid becomes 0 and the state returns to IDLE.
- in_valid during SWEEP is ignored, since in_ready is 0. There is no abort other than reset.
- The output is always one-hot or zero; no multi-bit patterns are legal.

## Timing
- Direct latency: the output updates on the edge that completes the transfer and is visible the following cycle. Full throughput is 1 transfer per cycle in IDLE/HOLD.
- Sweep:
  - Each of the OUT_W positions is visible for exactly CNT_MAX+1 cycles.
  - out_val returns to 0 exactly OUT_W*(CNT_MAX+1) cycles after the transfer edge.
  - in_ready rises in that same cycle, and a new transfer may be accepted at the next edge.
- CNT_MAX = 0: the lit bit advances every cycle and the sweep lasts OUT_W cycles.
- Transfer and sweep completion cannot coincide, because in_ready is 0 for the whole sweep.

## Configuration
- PARAM_DECODER_SWEEP_EN defined: SWEEP state, dwell counter, step counter and mode handling are compiled in, as described above.
- PARAM_DECODER_SWEEP_EN undefined:
  - SWEEP state and both counters are absent, and mode is ignored.
  - Every transfer is treated as direct, and in_ready is constant 1.
  - CNT_MAX is unused.

## Test plan
SEL_W=3 and CNT_MAX=3 unless stated; the macro is defined unless stated.
- Reset: assert sys_rst_n=0 → out_val=8'h00, out_valid=0, in_ready=1, both during reset and after release until the first transfer.
- Direct decode: transfer in_sel=0..7 with mode=0, one per cycle → one cycle after each transfer, out_val=8'h01, 02, 04, 08, 10, 20, 40, 80. Then drop in_valid → 8'h80 held for 20 cycles.
- Sweep with wrap: transfer in_sel=6, mode=1 → out_val steps through 8'h40, 80, 01, 02, 04, 08, 10, 20, each for 4 cycles, with in_ready=0 throughout. out_val=0 and in_ready=1 at cycle 32 after the transfer. An in_valid pulse with in_sel=1 at cycle 10 is ignored.
- Reset mid-sweep: start a sweep, then drop sys_rst_n between clock edges at cycle 9 → out_val=0 and out_valid=0 immediately; after release, state is IDLE and in_ready=1.
- Random soak: 10,000 cycles of random in_valid/in_sel/mode with SEL_W=4, CNT_MAX=0 → matches a reference model every cycle, and out_val is always one-hot or zero.
- Macro undefined: transfer in_sel=3, mode=1 → out_val=8'h08 the next cycle and held, with in_ready remaining 1.

Source files
------------

// File: rtl/param_decoder_if.sv
// Handshake and one-hot output bundle for param_decoder.
// The master drives requests and the slave (the decoder) drives the outputs.
interface param_decoder_if #(
  parameter int SEL_W = 3
);
  localparam int OUT_W = 1 << SEL_W;

  logic             in_valid;
  logic             in_ready;
  logic [SEL_W-1:0] in_sel;
  logic             mode;
  logic [OUT_W-1:0] out_val;
  logic             out_valid;

  modport master (
    output in_valid, in_sel, mode,
    input  in_ready, out_val, out_valid
  );

  modport slave (
    input  in_valid, in_sel, mode,
    output in_ready, out_val, out_valid
  );
endinterface

// File: rtl/param_decoder.sv
// Registered SEL_W-to-2^SEL_W one-hot decoder with a valid/ready input and
// an optional timed sweep mode, compiled in when PARAM_DECODER_SWEEP_EN is defined.
module param_decoder #(
  parameter int SEL_W   = 3,
  parameter int CNT_MAX = 24_999_999
) (
  input  logic           sys_clk,
  input  logic           sys_rst_n,
  param_decoder_if.slave bus
);
  localparam int OUT_W = 1 << SEL_W;

  logic [OUT_W-1:0] dec_val;
  logic [OUT_W-1:0] out_val_q;
  logic             out_valid_q;

  assign dec_val       = {{(OUT_W-1){1'b0}}, 1'b1} << bus.in_sel;
  assign bus.out_val   = out_val_q;
  assign bus.out_valid = out_valid_q;

`ifdef PARAM_DECODER_SWEEP_EN
  localparam int CW = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
  localparam logic [CW-1:0]    DWELL_MAX = CW'(CNT_MAX);
  localparam logic [SEL_W-1:0] STEP_LAST = '1;

  typedef enum logic [1:0] {IDLE, HOLD, SWEEP} state_t;

  state_t           state_q;
  logic [CW-1:0]    dwell_q;
  logic [SEL_W-1:0] step_q;

  assign bus.in_ready = (state_q != SWEEP);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= IDLE;
      out_val_q   <= '0;
      out_valid_q <= 1'b0;
      dwell_q     <= '0;
      step_q      <= '0;
    end else begin
      case (state_q)
        IDLE, HOLD: begin
          if (bus.in_valid) begin
            out_val_q   <= dec_val;
            out_valid_q <= 1'b1;
            if (bus.mode) begin
              dwell_q <= '0;
              step_q  <= '0;
              state_q <= SWEEP;
            end else begin
              state_q <= HOLD;
            end
          end
        end
        SWEEP: begin
          if (dwell_q == DWELL_MAX) begin
            dwell_q <= '0;
            step_q  <= step_q + SEL_W'(1);
            // Last position finished: blank the output and reopen the input.
            if (step_q == STEP_LAST) begin
              out_val_q   <= '0;
              out_valid_q <= 1'b0;
              state_q     <= IDLE;
            end else begin
              out_val_q <= {out_val_q[OUT_W-2:0], out_val_q[OUT_W-1]};
            end
          end else begin
            dwell_q <= dwell_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
`else
  typedef enum logic {IDLE, HOLD} state_t;

  state_t state_q;
  logic   unused_mode;
  localparam int unused_cnt_max = CNT_MAX;

  assign unused_mode  = bus.mode;
  assign bus.in_ready = 1'b1;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= IDLE;
      out_val_q   <= '0;
      out_valid_q <= 1'b0;
    end else if (bus.in_valid) begin
      out_val_q   <= dec_val;
      out_valid_q <= 1'b1;
      state_q     <= HOLD;
    end
  end
`endif
endmodule

// File: tb/tb_param_decoder.sv
// Self-checking bench for param_decoder: directed tests on an SEL_W=3/CNT_MAX=3
// instance and a random soak on an SEL_W=4/CNT_MAX=0 instance against a reference model.
module tb_param_decoder;
  localparam int A_SEL_W = 3;
  localparam int A_CM    = 3;
  localparam int B_SEL_W = 4;
  localparam int B_CM    = 0;
  localparam int B_OUT_W = 1 << B_SEL_W;

  typedef struct {
    logic [15:0] out;
    bit          busy;
    int          start;
    int          cyc;
  } model_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  param_decoder_if #(.SEL_W(A_SEL_W)) if_a ();
  param_decoder_if #(.SEL_W(B_SEL_W)) if_b ();

  param_decoder #(.SEL_W(A_SEL_W), .CNT_MAX(A_CM)) dut_a (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .bus       (if_a)
  );

  param_decoder #(.SEL_W(B_SEL_W), .CNT_MAX(B_CM)) dut_b (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .bus       (if_b)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Sweep position is derived from elapsed cycles since the transfer edge.
  function automatic model_t model_step(model_t m, bit v, int sel, bit md, int ow, int cm);
    model_t n;
    bit do_sweep;
    n = m;
`ifdef PARAM_DECODER_SWEEP_EN
    do_sweep = md;
`else
    do_sweep = md & 1'b0;
`endif
    if (m.busy) begin
      n.cyc = m.cyc + 1;
      if (n.cyc == ow * (cm + 1)) begin
        n.busy = 1'b0;
        n.out  = '0;
      end else begin
        n.out = 16'(1) << ((m.start + n.cyc / (cm + 1)) % ow);
      end
    end else if (v) begin
      n.out = 16'(1) << sel;
      if (do_sweep) begin
        n.busy  = 1'b1;
        n.start = sel;
        n.cyc   = 0;
      end
    end
    return n;
  endfunction

  initial begin
    model_t m;
    bit     v;
    bit     md;
    int     sel;

    if_a.in_valid = 1'b0; if_a.in_sel = '0; if_a.mode = 1'b0;
    if_b.in_valid = 1'b0; if_b.in_sel = '0; if_b.mode = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_val("rst_a_out",   32'(if_a.out_val),   32'h00);
    check_val("rst_a_valid", 32'(if_a.out_valid), 32'd0);
    check_val("rst_a_ready", 32'(if_a.in_ready),  32'd1);
    check_val("rst_b_out",   32'(if_b.out_val),   32'h0000);
    #3 rst_n = 1'b1;
    repeat (3) tick();
    check_val("post_rst_out",   32'(if_a.out_val),   32'h00);
    check_val("post_rst_valid", 32'(if_a.out_valid), 32'd0);
    check_val("post_rst_ready", 32'(if_a.in_ready),  32'd1);

    for (int s = 0; s < 8; s++) begin
      if_a.in_valid = 1'b1;
      if_a.in_sel   = 3'(s);
      if_a.mode     = 1'b0;
      tick();
      $display("direct sel=%0d out_val=%h out_valid=%0b", s, if_a.out_val, if_a.out_valid);
      check_val($sformatf("direct_out%0d", s), 32'(if_a.out_val), 32'(1) << s);
      check_val($sformatf("direct_valid%0d", s), 32'(if_a.out_valid), 32'd1);
    end
    if_a.in_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check_val($sformatf("hold%0d", i), 32'(if_a.out_val), 32'h80);
    end

`ifdef PARAM_DECODER_SWEEP_EN
    if_a.in_valid = 1'b1; if_a.in_sel = 3'd6; if_a.mode = 1'b1;
    tick();
    $display("sweep start sel=6 out_val=%h", if_a.out_val);
    if_a.mode = 1'b0;
    for (int c = 0; c < 32; c++) begin
      check_val($sformatf("sweep_out_c%0d", c), 32'(if_a.out_val), 32'(1) << ((6 + c / 4) % 8));
      check_val($sformatf("sweep_ready_c%0d", c), 32'(if_a.in_ready), 32'd0);
      if (c == 10) begin
        if_a.in_valid = 1'b1;
        if_a.in_sel   = 3'd1;
      end else begin
        if_a.in_valid = 1'b0;
      end
      tick();
    end
    $display("sweep end out_val=%h in_ready=%0b", if_a.out_val, if_a.in_ready);
    check_val("sweep_end_out",   32'(if_a.out_val),   32'h00);
    check_val("sweep_end_valid", 32'(if_a.out_valid), 32'd0);
    check_val("sweep_end_ready", 32'(if_a.in_ready),  32'd1);

    if_a.in_valid = 1'b1; if_a.in_sel = 3'd0; if_a.mode = 1'b1;
    tick();
    if_a.in_valid = 1'b0; if_a.mode = 1'b0;
    repeat (9) tick();
    check_val("pre_rst_out", 32'(if_a.out_val), 32'h04);
    #3 rst_n = 1'b0;
    #1;
    $display("mid-sweep reset out_val=%h out_valid=%0b", if_a.out_val, if_a.out_valid);
    check_val("midrst_out",   32'(if_a.out_val),   32'h00);
    check_val("midrst_valid", 32'(if_a.out_valid), 32'd0);
    check_val("midrst_ready", 32'(if_a.in_ready),  32'd1);
    #3 rst_n = 1'b1;
    tick();
    check_val("after_midrst_out",   32'(if_a.out_val),  32'h00);
    check_val("after_midrst_ready", 32'(if_a.in_ready), 32'd1);
`else
    if_a.in_valid = 1'b1; if_a.in_sel = 3'd3; if_a.mode = 1'b1;
    tick();
    if_a.in_valid = 1'b0; if_a.mode = 1'b0;
    $display("no-sweep sel=3 mode=1 out_val=%h", if_a.out_val);
    check_val("nosweep_out",   32'(if_a.out_val),  32'h08);
    check_val("nosweep_ready", 32'(if_a.in_ready), 32'd1);
    for (int i = 0; i < 8; i++) begin
      tick();
      check_val($sformatf("nosweep_hold%0d", i), 32'(if_a.out_val), 32'h08);
      check_val($sformatf("nosweep_ready%0d", i), 32'(if_a.in_ready), 32'd1);
    end
`endif

    m = '{out: 16'h0, busy: 1'b0, start: 0, cyc: 0};
    for (int i = 0; i < 10000; i++) begin
      v   = ($urandom_range(0, 3) != 0);
      md  = ($urandom_range(0, 4) == 0);
      sel = int'($urandom_range(0, B_OUT_W - 1));
      if_b.in_valid = v;
      if_b.in_sel   = 4'(sel);
      if_b.mode     = md;
      m = model_step(m, v, sel, md, B_OUT_W, B_CM);
      tick();
      check_val("soak_out",    32'(if_b.out_val),   32'(m.out));
      check_val("soak_valid",  32'(if_b.out_valid), 32'(m.out != 0));
      check_val("soak_ready",  32'(if_b.in_ready),  32'(!m.busy));
      check_val("soak_onehot", 32'($countones(if_b.out_val) <= 1), 32'd1);
    end
    if_b.in_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
